cpu_clock_ctrl: RTL
===================

Name: cpu_clock_ctrl

Overview:
Parametrised CPU clock-enable controller; the successor to the fixed power-of-two divider in the board top level. Runs on the board clock and issues single-cycle cpu_ce pulses, so the CPU can run on fastclk with a clock enable instead of a derived clock. Supports run-time selectable rate, single-step from a debounced push button, halt request from the CPU, and a debug pulse counter. Sits between the board pins and the CPU in the top level.

Parameters:
CNT_WIDTH, 25, width of the rate counter; maximum period is 2^CNT_WIDTH fastclk cycles.
DEB_CYCLES, 500000, fastclk cycles the synchronised button must be stable before the debounced level changes (10 ms at 50 MHz).
DEB_WIDTH, 20, width of the debounce counter; must satisfy 2^DEB_WIDTH > DEB_CYCLES.
CNT_BITS, 16, width of ce_count.

Ports:
fastclk     input   1          board clock; the only clock.
reset       input   1          synchronous, active-high reset.
mode        input   2          00 halt, 01 run, 10 step, 11 treated as halt.
div_sel     input   5          run period = 2^div_sel fastclk cycles; values > CNT_WIDTH are clamped to CNT_WIDTH.
step_btn    input   1          raw asynchronous push button, active-high.
cpu_halt    input   1          CPU halt request, synchronous to fastclk.
cpu_ce      output  1          one-fastclk-cycle enable pulse to the CPU.
cpu_clk     output  1          display square wave; toggles on every cpu_ce.
running     output  1          high while in RUN state.
ce_count    output  CNT_BITS   number of cpu_ce pulses issued; wraps.

Behaviour:
- Reset values: cpu_ce=0, cpu_clk=0, running=0, ce_count=0. Rate counter=0, debounce counter=0, debounced level=0, synchroniser FFs=0, state=IDLE. Reset takes priority over every other event in the same cycle.
- Button path: 2-FF synchroniser on step_btn.
  - Debounce counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments. When it reaches DEB_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
  - A rising edge of the debounced level produces step_req, a one-cycle internal pulse.
- FSM states:
  - IDLE: mode is not 01/10. No cpu_ce.
  - RUN: mode==01 and not halted. Rate counter counts 0..2^d-1, where d = min(div_sel, CNT_WIDTH). cpu_ce=1 in the cycle the counter equals 2^d-1; the counter wraps to 0 that cycle. d=0 gives cpu_ce every cycle.
  - STOPPED: entered from RUN when cpu_halt=1 (sampled every cycle). No cpu_ce. Leaves only when mode!=01 (goes to IDLE or STEP). cpu_halt in the same cycle as a terminal count: that pulse is still issued, and STOPPED is entered next cycle.
  - STEP: mode==10. Each step_req gives exactly one cpu_ce, registered, one cycle after step_req. cpu_halt is ignored in STEP.
- Transitions are evaluated every cycle from mode: 01→RUN (unless STOPPED), 10→STEP, else IDLE.
- Any mode change or div_sel change clears the rate counter. Change detection uses the registered previous value. The first RUN pulse after entry comes 2^d cycles later.
- A step_req arriving while not in STEP is discarded, not queued.
- cpu_ce is registered, so it is never high on two consecutive cycles except when RUN has d=0.
- cpu_clk toggles in the cycle cpu_ce is high (registered alongside it).
- ce_count increments by 1 per cpu_ce and wraps from 2^CNT_BITS-1 to 0.
- running = (state==RUN), registered.
- Mid-operation reset: all state returns to reset values the next edge. Any pending step_req or partial debounce count is lost.

Test Plan:
- Reset, then mode=01, div_sel=2 → cpu_ce pulses every 4 cycles, first pulse 4 cycles after entry. cpu_clk toggles each pulse. ce_count=5 after 20 cycles. running=1.
- mode=01, div_sel=0 → cpu_ce high every cycle. Then div_sel=31 with CNT_WIDTH=6 → clamped period of 64 cycles. Changing div_sel mid-count restarts the period from 0.
- mode=01, div_sel=3, cpu_halt pulsed high coincident with a terminal count → that pulse is issued, then no further cpu_ce and running=0. Switch mode 00 then 01 → pulses resume after 8 cycles.
- DEB_CYCLES=4, mode=10: button bounces 1-0-1-0 at 2-cycle spacing, then holds high 10 cycles → exactly one cpu_ce, ce_count=1. Release and press cleanly again → ce_count=2. A press while mode=00 → no pulse.
- ce_count preset near wrap: CNT_BITS=4, 17 pulses in run mode with d=0 → ce_count=1.
- reset asserted for 1 cycle during RUN with the counter at 2 (div_sel=2) → next cycle all outputs 0, state IDLE. With mode still 01, the first pulse arrives 4 cycles after the FSM re-enters RUN.

Source files
------------

// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between board pins, CPU and the clock-enable controller.
// Latency: none, plain wires.
// Backpressure: none, all signals are level or single-cycle pulses.
interface cpu_clock_ctrl_if #(
  parameter int CNT_BITS = 16
);
  logic [1:0]          mode;
  logic [4:0]          div_sel;
  logic                step_btn;
  logic                cpu_halt;
  logic                cpu_ce;
  logic                cpu_clk;
  logic                running;
  logic [CNT_BITS-1:0] ce_count;

  // master: board/CPU side driving the controls; slave: the controller itself
  modport master (output mode, div_sel, step_btn, cpu_halt,
                  input  cpu_ce, cpu_clk, running, ce_count);
  modport slave  (input  mode, div_sel, step_btn, cpu_halt,
                  output cpu_ce, cpu_clk, running, ce_count);
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: run at 2^d rate, single-step from a debounced button, halt from CPU.
// Latency: cpu_ce registered; RUN first pulse 2^d cycles after entry, STEP pulse 1 cycle after step_req.
// Backpressure: none; step requests outside STEP and ticks while halted are dropped, never queued.
module cpu_clock_ctrl #(
  parameter int CNT_WIDTH  = 25,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_WIDTH  = 20,
  parameter int CNT_BITS   = 16
) (
  input  logic            i_fastclk,
  input  logic            i_reset,
  cpu_clock_ctrl_if.slave io_ctl
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPED, S_STEP} state_t;

  localparam logic [1:0]           MODE_RUN  = 2'b01;
  localparam logic [1:0]           MODE_STEP = 2'b10;
  localparam logic [DEB_WIDTH-1:0] DEB_LAST  = DEB_WIDTH'(DEB_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_deb_lvl;
  logic                 r_step_req;
  logic [DEB_WIDTH-1:0] r_deb_cnt;
  logic [CNT_WIDTH-1:0] r_rate_cnt;
  logic [1:0]           r_mode_prev;
  logic [4:0]           r_div_prev;
  logic                 r_cpu_ce;
  logic                 r_cpu_clk;
  logic                 r_running;
  logic [CNT_BITS-1:0]  r_ce_count;

  logic                 w_deb_rise;
  logic                 w_cfg_change;
  logic                 w_term;
  logic                 w_ce_next;
  logic                 w_run_next;
  logic [4:0]           w_div;
  logic [CNT_WIDTH-1:0] w_term_val;

  // Clamp the divider exponent so the terminal value always fits the rate counter.
  assign w_div        = (int'(io_ctl.div_sel) > CNT_WIDTH) ? 5'(CNT_WIDTH) : io_ctl.div_sel;
  assign w_term_val   = ~({CNT_WIDTH{1'b1}} << w_div);
  assign w_term       = (r_rate_cnt == w_term_val);
  assign w_cfg_change = (io_ctl.mode != r_mode_prev) || (io_ctl.div_sel != r_div_prev);
  // Debounced level is about to go 0->1 at the coming edge.
  assign w_deb_rise   = r_sync2 && !r_deb_lvl && (r_deb_cnt == DEB_LAST);

  // Button synchroniser, debounce counter and one-cycle step request.
  always_ff @(posedge i_fastclk) begin
    if (i_reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb_cnt  <= '0;
      r_deb_lvl  <= 1'b0;
      r_step_req <= 1'b0;
    end else begin
      r_sync1    <= io_ctl.step_btn;
      r_sync2    <= r_sync1;
      r_step_req <= w_deb_rise;
      if (r_sync2 == r_deb_lvl) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb_lvl <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_WIDTH'(1);
      end
    end
  end

  // Rate counter: restarts on any config change or outside RUN, wraps at the terminal count.
  always_ff @(posedge i_fastclk) begin
    if (i_reset) begin
      r_rate_cnt  <= '0;
      r_mode_prev <= 2'b00;
      r_div_prev  <= 5'd0;
    end else begin
      r_mode_prev <= io_ctl.mode;
      r_div_prev  <= io_ctl.div_sel;
      if (w_cfg_change || (r_state != S_RUN) || w_term) begin
        r_rate_cnt <= '0;
      end else begin
        r_rate_cnt <= r_rate_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_fastclk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: mode decides, except a halted RUN stays stopped until mode leaves 01.
  always_comb begin
    w_next_state = S_IDLE;
    if (io_ctl.mode == MODE_RUN) begin
      if ((r_state == S_STOPPED) || ((r_state == S_RUN) && io_ctl.cpu_halt)) begin
        w_next_state = S_STOPPED;
      end else begin
        w_next_state = S_RUN;
      end
    end else if (io_ctl.mode == MODE_STEP) begin
      w_next_state = S_STEP;
    end
  end

  // FSM outputs: pulse on terminal count in RUN (unless restarting), or on a step request in STEP.
  always_comb begin
    w_ce_next  = 1'b0;
    w_run_next = (w_next_state == S_RUN);
    case (r_state)
      S_RUN:   w_ce_next = w_term && !w_cfg_change;
      S_STEP:  w_ce_next = r_step_req;
      default: w_ce_next = 1'b0;
    endcase
  end

  // Registered outputs: enable pulse, display square wave, pulse counter, running flag.
  always_ff @(posedge i_fastclk) begin
    if (i_reset) begin
      r_cpu_ce   <= 1'b0;
      r_cpu_clk  <= 1'b0;
      r_running  <= 1'b0;
      r_ce_count <= '0;
    end else begin
      r_cpu_ce  <= w_ce_next;
      r_running <= w_run_next;
      if (w_ce_next) begin
        r_cpu_clk  <= ~r_cpu_clk;
        r_ce_count <= r_ce_count + CNT_BITS'(1);
      end
    end
  end

  assign io_ctl.cpu_ce   = r_cpu_ce;
  assign io_ctl.cpu_clk  = r_cpu_clk;
  assign io_ctl.running  = r_running;
  assign io_ctl.ce_count = r_ce_count;
endmodule
